// File: rtl/dijkstra_burst_reader.sv
// Multi-word Avalon-MM burst reader for the Dijkstra custom instruction.
// Reads word_count words one at a time and reduces them to a sum (+datab) or a minimum with index.
module dijkstra_burst_reader #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 8,
  parameter int RES_W   = 32,
  parameter int STRIDE  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              algorithm_clock,
  input  logic              algorithm_reset_n,
  input  logic              algorithm_start,
  input  logic              algorithm_enable,
  input  logic [ADDR_W-1:0] base_address,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [RES_W-1:0]  datab,
  input  logic              op_mode,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              wait_request,
  input  logic              mem_read_ready,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [RES_W-1:0]  shortest_distance,
  output logic [CNT_W-1:0]  min_index,
  output logic              ready,
  output logic              busy,
  output logic              error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_reg, addr_n;
  logic [CNT_W-1:0]  cnt_reg, cnt_n;
  logic [RES_W-1:0]  datab_reg, datab_n;
  logic              mode_reg, mode_n;
  logic [CNT_W-1:0]  idx, idx_n;
  logic [RES_W-1:0]  acc, acc_n;
  logic [CNT_W-1:0]  min_idx, min_idx_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic              mre_n, ready_n, busy_n, error_n;
  logic [RES_W-1:0]  sd_n;
  logic [CNT_W-1:0]  mi_n;
  logic [RES_W-1:0]  d;
  logic              tmo;

  assign d        = RES_W'(mem_read_data);
  assign tmo      = (tcnt == TW'(TIMEOUT - 1));
  assign mem_addr = addr_reg;

  always_ff @(posedge algorithm_clock or negedge algorithm_reset_n) begin
    if (!algorithm_reset_n) begin
      state             <= IDLE;
      addr_reg          <= '0;
      cnt_reg           <= '0;
      datab_reg         <= '0;
      mode_reg          <= 1'b0;
      idx               <= '0;
      acc               <= '0;
      min_idx           <= '0;
      tcnt              <= '0;
      mem_read_enable   <= 1'b0;
      shortest_distance <= '0;
      min_index         <= '0;
      ready             <= 1'b0;
      busy              <= 1'b0;
      error             <= 1'b0;
    end else begin
      state             <= state_n;
      addr_reg          <= addr_n;
      cnt_reg           <= cnt_n;
      datab_reg         <= datab_n;
      mode_reg          <= mode_n;
      idx               <= idx_n;
      acc               <= acc_n;
      min_idx           <= min_idx_n;
      tcnt              <= tcnt_n;
      mem_read_enable   <= mre_n;
      shortest_distance <= sd_n;
      min_index         <= mi_n;
      ready             <= ready_n;
      busy              <= busy_n;
      error             <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr_reg;
    cnt_n     = cnt_reg;
    datab_n   = datab_reg;
    mode_n    = mode_reg;
    idx_n     = idx;
    acc_n     = acc;
    min_idx_n = min_idx;
    tcnt_n    = tcnt;
    mre_n     = mem_read_enable;
    sd_n      = shortest_distance;
    mi_n      = min_index;
    ready_n   = 1'b0;
    error_n   = error;
    case (state)
      IDLE: begin
        if (algorithm_start && algorithm_enable) begin
          addr_n    = base_address;
          cnt_n     = word_count;
          datab_n   = datab;
          mode_n    = op_mode;
          error_n   = 1'b0;
          idx_n     = '0;
          acc_n     = op_mode ? '1 : '0;
          min_idx_n = '0;
          tcnt_n    = '0;
          if (word_count == '0) begin
            state_n = DONE;
          end else begin
            state_n = REQ;
            mre_n   = 1'b1;
          end
        end
      end
      REQ: begin
        tcnt_n = tcnt + TW'(1);
        if (tmo) begin
          state_n = DONE;
          mre_n   = 1'b0;
          error_n = 1'b1;
        end else if (mem_read_enable) begin
          // an issued request stays on the bus until the slave takes it
          if (!wait_request) begin
            state_n = WAIT_DATA;
            mre_n   = 1'b0;
          end
        end else begin
          mre_n = algorithm_enable;
        end
      end
      WAIT_DATA: begin
        tcnt_n = tcnt + TW'(1);
        if (mem_read_ready) begin
          tcnt_n = '0;
          if (mode_reg) begin
            if (d < acc) begin
              acc_n     = d;
              min_idx_n = idx;
            end
          end else begin
            acc_n = acc + d;
          end
          idx_n  = idx + CNT_W'(1);
          addr_n = addr_reg + ADDR_W'(STRIDE);
          if (idx == cnt_reg - CNT_W'(1)) begin
            state_n = DONE;
          end else begin
            state_n = REQ;
            mre_n   = algorithm_enable;
          end
        end else if (tmo) begin
          state_n = DONE;
          error_n = 1'b1;
        end
      end
      DONE: begin
        ready_n = 1'b1;
        sd_n    = mode_reg ? acc : acc + datab_reg;
        mi_n    = mode_reg ? min_idx : '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_dijkstra_burst_reader.sv
// Directed bench for dijkstra_burst_reader: a small Avalon-style responder plus
// hand-computed results for sum, min, stall, zero-count, timeout and reset cases.
module tb_dijkstra_burst_reader;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, enable, op_mode;
  logic [31:0] base_address;
  logic [7:0]  word_count;
  logic [31:0] datab;
  logic        mem_read_enable;
  logic [31:0] mem_addr;
  logic        wait_request;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [31:0] shortest_distance;
  logic [7:0]  min_index;
  logic        ready, busy, error;

  always #5 clk = ~clk;

  dijkstra_burst_reader #(.TIMEOUT(TIMEOUT)) dut (
    .algorithm_clock   (clk),
    .algorithm_reset_n (rst_n),
    .algorithm_start   (start),
    .algorithm_enable  (enable),
    .base_address      (base_address),
    .word_count        (word_count),
    .datab             (datab),
    .op_mode           (op_mode),
    .mem_read_enable   (mem_read_enable),
    .mem_addr          (mem_addr),
    .wait_request      (wait_request),
    .mem_read_ready    (mem_read_ready),
    .mem_read_data     (mem_read_data),
    .shortest_distance (shortest_distance),
    .min_index         (min_index),
    .ready             (ready),
    .busy              (busy),
    .error             (error)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // memory responder: decisions made on the falling edge for the next rising edge
  logic [15:0] mem_data [8];
  logic [31:0] cur_base = '0;
  logic [31:0] addr_log [$];
  int          stall_word = -1;
  int          stall_left = 0;
  bit          never_resp = 0;
  bit          pending = 0;
  int          resp_word = 0;
  int          mre_seen = 0;
  int          ready_seen = 0;

  always @(negedge clk) begin
    if (mem_read_enable) mre_seen++;
    if (ready) ready_seen++;
    mem_read_ready = 1'b0;
    if (pending) begin
      pending = 0;
      if (!never_resp) begin
        mem_read_ready = 1'b1;
        mem_read_data  = mem_data[resp_word[2:0]];
      end
    end
    wait_request = 1'b0;
    if (mem_read_enable) begin
      resp_word = int'((mem_addr - cur_base) >> 1);
      if (resp_word == stall_word && stall_left > 0) begin
        check("stall_addr", mem_addr, cur_base + 32'(2 * stall_word));
        stall_left--;
        wait_request = 1'b1;
      end else begin
        pending = 1;
        addr_log.push_back(mem_addr);
      end
    end
  end

  task automatic set_mem(input logic [15:0] a, b, c, e);
    mem_data[0] = a; mem_data[1] = b; mem_data[2] = c; mem_data[3] = e;
  endtask

  // starts one operation and returns after ready is seen (or the bound expires)
  int lat;
  logic busy1, err1;
  task automatic run(input logic m, input logic [31:0] base, input logic [7:0] cnt, input logic [31:0] db);
    @(negedge clk);
    cur_base = base; base_address = base; word_count = cnt; datab = db; op_mode = m;
    enable = 1'b1; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0; busy1 = busy; err1 = error;
      end
    end while (!ready && lat < 2000);
    check("ready_seen", ready, 1'b1);
  endtask

  initial begin
    int r0, m0;
    for (int i = 0; i < 8; i++) mem_data[i] = '0;
    rst_n = 1'b0; start = 1'b0; enable = 1'b1; op_mode = 1'b0;
    base_address = '0; word_count = '0; datab = '0;
    wait_request = 1'b0; mem_read_ready = 1'b0; mem_read_data = '0;
    #1;
    check("rst_mre", mem_read_enable, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_sd", shortest_distance, 0);
    check("rst_ready_busy_err", {ready, busy, error}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // sum of 5,7,9 plus 10
    set_mem(5, 7, 9, 0);
    addr_log.delete(); r0 = ready_seen;
    run(1'b0, 32'h100, 3, 10);
    check("t1_busy", busy1, 1);
    check("t1_sd", shortest_distance, 31);
    check("t1_err", error, 0);
    check("t1_naddr", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      check("t1_a0", addr_log[0], 32'h100);
      check("t1_a1", addr_log[1], 32'h102);
      check("t1_a2", addr_log[2], 32'h104);
    end
    repeat (3) @(negedge clk);
    check("t1_pulses", ready_seen - r0, 1);
    check("t1_idle", busy, 0);

    // minimum with a tie: first index wins
    set_mem(40, 12, 30, 12);
    run(1'b1, 32'h180, 4, 32'h55);
    check("t2_sd", shortest_distance, 12);
    check("t2_idx", min_index, 1);

    // zero extension and wrap of the sum; min_index reads 0 in sum mode
    set_mem(16'hFFFF, 16'h0001, 0, 0);
    run(1'b0, 32'h1000, 2, 32'hFFFF_0000);
    check("wrap_sd", shortest_distance, 0);
    check("wrap_idx", min_index, 0);

    // stall on word 1 for 5 cycles
    set_mem(100, 200, 300, 0);
    stall_word = 1; stall_left = 5;
    run(1'b0, 32'h200, 3, 0);
    check("t3_sd", shortest_distance, 600);
    check("t3_stalls_left", stall_left, 0);
    stall_word = -1;

    // zero count: no memory traffic, ready two cycles after start
    m0 = mre_seen;
    run(1'b0, 32'h300, 0, 32'h1234);
    check("t4_lat", lat, 2);
    check("t4_sd0", shortest_distance, 32'h1234);
    run(1'b1, 32'h300, 0, 32'h1234);
    check("t4_sd1", shortest_distance, 32'hFFFF_FFFF);
    check("t4_idx", min_index, 0);
    check("t4_no_mre", mre_seen - m0, 0);

    // start with enable low is not accepted
    @(negedge clk);
    start = 1'b1; enable = 1'b0;
    @(negedge clk);
    check("en_low_busy", busy, 0);
    start = 1'b0; enable = 1'b1;

    // word 0 never returns: timeout with partial result (0 + datab)
    never_resp = 1;
    run(1'b0, 32'h400, 2, 7);
    check("t5_err", error, 1);
    check("t5_sd", shortest_distance, 7);
    check("t5_lat", (lat >= TIMEOUT && lat <= TIMEOUT + 2), 1);
    never_resp = 0;
    set_mem(5, 7, 9, 0);
    run(1'b0, 32'h100, 3, 10);
    check("t5_err_clr_at_start", err1, 0);
    check("t5_err_after", error, 0);
    check("t5_sd_after", shortest_distance, 31);

    // reset while waiting for data
    never_resp = 1;
    @(negedge clk);
    cur_base = 32'h500; base_address = 32'h500; word_count = 2; op_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    r0 = ready_seen;
    #2 rst_n = 1'b0;
    #1;
    check("t6_mre", mem_read_enable, 0);
    check("t6_addr", mem_addr, 0);
    check("t6_sd", shortest_distance, 0);
    check("t6_flags", {ready, busy, error}, 0);
    pending = 0; never_resp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_no_ready", ready_seen - r0, 0);
    set_mem(40, 12, 30, 12);
    run(1'b1, 32'h600, 4, 0);
    check("t6_sd_after", shortest_distance, 12);
    check("t6_idx_after", min_index, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
